// File: rtl/npc_unit.sv
// npc_unit: next-PC generator for the fetch stage.
//
// Picks the value written into the PC register each cycle. The sources, from
// highest to lowest priority, are: exception vector, ERET return address, a
// taken branch/jump target, a held redirect, and PC+4. The block also owns
// the EPC register and raises FlushF on exception entry and on ERET.
//
// State (st) | meaning
// RUN        | no redirect held; follow the inputs
// PEND       | a taken branch arrived during a stall; pend_tgt is issued
//            | when fetch resumes
//
// Ports:
//   Clk, Reset      rising-edge clock, synchronous active-high reset
//   PC              current fetch address
//   Stall           fetch stall request
//   BrTaken         one-cycle pulse, taken branch/jump in D
//   BrTarget        branch/jump target (bits [1:0] ignored)
//   ExcReq          one-cycle pulse, exception taken
//   ExcPC           PC of the faulting instruction
//   InDelaySlot     faulting instruction sits in a delay slot
//   Eret            one-cycle pulse, ERET executing
//   NPC             next PC value
//   PCEn            PC register write enable
//   FlushF          squash the instruction in F
//   EPC             exception return address register
module npc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic        ExcReq,
  input  logic [31:0] ExcPC,
  input  logic        InDelaySlot,
  input  logic        Eret,
  output logic [31:0] NPC,
  output logic        PCEn,
  output logic        FlushF,
  output logic [31:0] EPC
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} st_t;

  st_t         st;
  logic [31:0] pend_tgt;
  logic [31:0] br_tgt;
  logic [31:0] pc_plus4;
  logic [31:0] epc_next;

  // Masking the whole word keeps every target bit read.
  assign br_tgt   = BrTarget & 32'hFFFF_FFFC;
  assign pc_plus4 = PC + 32'd4;
  // A fault in a delay slot returns to the branch so it is re-executed.
  assign epc_next = (InDelaySlot ? (ExcPC - 32'd4) : ExcPC) & 32'hFFFF_FFFC;

  always_comb begin
    NPC    = pc_plus4;
    PCEn   = ~Stall;
    FlushF = 1'b0;
    if (Reset) begin
      NPC  = RESET_PC;
      PCEn = 1'b1;
    end else if (ExcReq) begin
      NPC    = EXC_VECTOR;
      PCEn   = 1'b1;
      FlushF = 1'b1;
    end else if (Eret) begin
      NPC    = EPC;
      PCEn   = 1'b1;
      FlushF = 1'b1;
    end else if (BrTaken) begin
      // Under a stall the target is captured into pend_tgt instead.
      if (!Stall) NPC = br_tgt;
    end else if (st == PEND) begin
      if (!Stall) NPC = pend_tgt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st       <= RUN;
      pend_tgt <= 32'd0;
      EPC      <= 32'd0;
    end else if (ExcReq) begin
      EPC      <= epc_next;
      st       <= RUN;
      pend_tgt <= 32'd0;
    end else if (Eret) begin
      st       <= RUN;
      pend_tgt <= 32'd0;
    end else if (BrTaken) begin
      if (Stall) begin
        pend_tgt <= br_tgt;
        st       <= PEND;
      end else begin
        // Issued directly; an older held target is dropped.
        st <= RUN;
      end
    end else if (st == PEND && !Stall) begin
      st <= RUN;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
module tb_npc_unit;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BrTaken, ExcReq, InDelaySlot, Eret;
  logic [31:0] PC, BrTarget, ExcPC;
  logic [31:0] NPC, EPC;
  logic        PCEn, FlushF;

  int checks = 0;
  int failures = 0;

  npc_unit dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Stall(Stall), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .ExcReq(ExcReq), .ExcPC(ExcPC),
    .InDelaySlot(InDelaySlot), .Eret(Eret), .NPC(NPC), .PCEn(PCEn),
    .FlushF(FlushF), .EPC(EPC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        exc;
    logic [31:0] excpc;
    logic        ids, eret;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        chk_npc, pcen, flush;
    logic [31:0] epc;
    logic        chk_epc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic cmp(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then step past the edge.
  task automatic run_vec(string tag, int idx, vec_t v);
    Reset = v.rst; Stall = v.stall; BrTaken = v.br; BrTarget = v.tgt;
    ExcReq = v.exc; ExcPC = v.excpc; InDelaySlot = v.ids; Eret = v.eret;
    PC = v.pc;
    #2;
    if (v.chk_npc) cmp({tag, ".npc"}, idx, NPC, v.npc);
    cmp({tag, ".pcen"}, idx, {31'd0, PCEn}, {31'd0, v.pcen});
    cmp({tag, ".flush"}, idx, {31'd0, FlushF}, {31'd0, v.flush});
    if (v.chk_epc) cmp({tag, ".epc"}, idx, EPC, v.epc);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // rst stall br tgt exc excpc ids eret pc | npc chk pcen flush epc chk
    vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h0,        32'h3000,1'b1,1'b1,1'b0,32'h0,   1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h0,        32'h3000,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3000,     32'h3004,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b1,32'h3103,1'b0,32'h0,   1'b0,1'b0,32'h3008,     32'h3100,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3100,     32'h3104,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b1,32'h3200,1'b0,32'h0,   1'b0,1'b0,32'h3104,     32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b1};
    vecs[6]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3104,     32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3104,     32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3104,     32'h3200,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3200,     32'h3204,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[10] = '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h3010,1'b1,1'b0,32'h3204,     32'h4180,1'b1,1'b1,1'b1,32'h0,   1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h4180,     32'h4184,1'b1,1'b1,1'b0,32'h300C,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,32'h0,   1'b1,32'h3020,1'b0,1'b0,32'h4184,     32'h4180,1'b1,1'b1,1'b1,32'h300C,1'b1};
    vecs[13] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h4180,     32'h4184,1'b1,1'b1,1'b0,32'h3020,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b1,32'h3500,1'b0,32'h0,   1'b0,1'b1,32'h4184,     32'h3020,1'b1,1'b1,1'b1,32'h3020,1'b1};
    vecs[15] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3020,     32'h3024,1'b1,1'b1,1'b0,32'h3020,1'b1};
    vecs[16] = '{1'b0,1'b1,1'b1,32'h3300,1'b0,32'h0,   1'b0,1'b0,32'h3024,     32'h0,   1'b0,1'b0,1'b0,32'h3020,1'b1};
    vecs[17] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3024,     32'h0,   1'b0,1'b0,1'b0,32'h3020,1'b1};
    vecs[18] = '{1'b1,1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3024,     32'h3000,1'b1,1'b1,1'b0,32'h3020,1'b1};
    vecs[19] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h3000,     32'h3004,1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[20] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'hFFFF_FFFC,32'h0,   1'b1,1'b1,1'b0,32'h0,   1'b1};
    vecs[21] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b1,32'h3000,     32'h0,   1'b1,1'b1,1'b1,32'h0,   1'b1};

    for (int i = 0; i < NV; i++) run_vec("tbl", i, vecs[i]);

    // Newer branch under stall overwrites the held target.
    run_vec("ovr", 0, '{1'b0,1'b1,1'b1,32'h3400,1'b0,32'h0,1'b0,1'b0,32'h3000, 32'h0,   1'b0,1'b0,1'b0,32'h0,1'b1});
    run_vec("ovr", 1, '{1'b0,1'b1,1'b1,32'h3506,1'b0,32'h0,1'b0,1'b0,32'h3000, 32'h0,   1'b0,1'b0,1'b0,32'h0,1'b1});
    run_vec("ovr", 2, '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,1'b0,1'b0,32'h3000, 32'h3504,1'b1,1'b1,1'b0,32'h0,1'b1});
    run_vec("ovr", 3, '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,1'b0,1'b0,32'h3504, 32'h3508,1'b1,1'b1,1'b0,32'h0,1'b1});

    // Branch coinciding with release wins; held target dropped.
    run_vec("rel", 0, '{1'b0,1'b1,1'b1,32'h3600,1'b0,32'h0,1'b0,1'b0,32'h3508, 32'h0,   1'b0,1'b0,1'b0,32'h0,1'b1});
    run_vec("rel", 1, '{1'b0,1'b0,1'b1,32'h3700,1'b0,32'h0,1'b0,1'b0,32'h3508, 32'h3700,1'b1,1'b1,1'b0,32'h0,1'b1});
    run_vec("rel", 2, '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,1'b0,1'b0,32'h3700, 32'h3704,1'b1,1'b1,1'b0,32'h0,1'b1});

    // Exception discards a pending redirect.
    run_vec("exd", 0, '{1'b0,1'b1,1'b1,32'h3800,1'b0,32'h0,   1'b0,1'b0,32'h3704, 32'h0,   1'b0,1'b0,1'b0,32'h0,   1'b1});
    run_vec("exd", 1, '{1'b0,1'b1,1'b0,32'h0,   1'b1,32'h3801,1'b0,1'b0,32'h3704, 32'h4180,1'b1,1'b1,1'b1,32'h0,   1'b1});
    run_vec("exd", 2, '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h4180, 32'h4184,1'b1,1'b1,1'b0,32'h3800,1'b1});
    run_vec("exd", 3, '{1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,32'h4184, 32'h4188,1'b1,1'b1,1'b0,32'h3800,1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Next-PC generator for the fetch stage; drives the NPC and PCEn inputs of the PC register.
- Selects among sequential PC+4, taken branch/jump target from D, exception vector, and ERET return address.
- Holds a redirect that arrives while fetch is stalled until fetch resumes.
- Owns the EPC register and issues the fetch-squash signal for exception entry and ERET.

Parameters:
RESET_PC, 32'h0000_3000, value driven on NPC while Reset is high.
EXC_VECTOR, 32'h0000_4180, exception handler entry address.

Ports:
Clk  input  1  clock, rising edge.
Reset  input  1  synchronous, active-high.
PC  input  32  current fetch address from the PC register.
Stall  input  1  fetch stall request from the hazard unit.
BrTaken  input  1  one-cycle pulse: branch/jump in D resolved taken.
BrTarget  input  32  redirect target; valid when BrTaken=1.
ExcReq  input  1  one-cycle pulse: exception taken.
ExcPC  input  32  PC of the faulting instruction.
InDelaySlot  input  1  faulting instruction is in a branch delay slot.
Eret  input  1  one-cycle pulse: ERET executing.
NPC  output  32  next PC value.
PCEn  output  1  write enable to the PC register.
FlushF  output  1  squash the instruction currently in F.
EPC  output  32  exception return address register.

Behaviour:
- State registers: st (RUN/PEND), pend_tgt[31:0], EPC[31:0]. NPC, PCEn and FlushF are combinational from state and inputs.
- Reset is synchronous and active-high. While Reset=1: NPC=RESET_PC, PCEn=1, FlushF=0. On the clock edge, st<=RUN, pend_tgt<=0, EPC<=0.
- Reset mid-PEND discards the held redirect.
- Source priority, highest first: ExcReq > Eret > BrTaken > PEND held target > PC+4.
- ExcReq:
  - NPC=EXC_VECTOR, PCEn=1 even when Stall=1, FlushF=1.
  - Next edge: EPC <= InDelaySlot ? ExcPC-4 : ExcPC, with bits[1:0] forced to 00; st<=RUN; any pending redirect is discarded.
- Eret (no ExcReq):
  - NPC=EPC, PCEn=1 even when Stall=1, FlushF=1.
  - Next edge: st<=RUN, pending redirect discarded.
- BrTaken, Stall=0: NPC={BrTarget[31:2],2'b00}, PCEn=1, FlushF=0. The delay-slot instruction already in F is kept.
- BrTaken, Stall=1: PCEn=0, NPC=PC+4 (don't-care). Next edge: pend_tgt<={BrTarget[31:2],2'b00}, st<=PEND.
- BrTaken while already in PEND: the newer target overwrites pend_tgt.
- PEND, Stall=1, no higher event: PCEn=0; pend_tgt is held.
- PEND, Stall=0: NPC=pend_tgt, PCEn=1. Next edge: st<=RUN.
- If a BrTaken pulse coincides with the PEND release, BrTaken wins and pend_tgt is dropped.
- RUN, no event: NPC=PC+4 (32-bit, wraps 32'hFFFF_FFFC -> 0), PCEn=~Stall, FlushF=0.
- Latency: every redirect is visible on NPC in the same cycle as its pulse. The PC register takes the value at the next edge.
- EPC changes only on ExcReq or Reset. ERET does not modify it.

Test Plan:
- Reset 2 cycles, then release with Stall=0 -> during reset NPC=0x3000, PCEn=1, EPC=0. After release, with PC=0x3000: NPC=0x3004, PCEn=1, FlushF=0.
- PC=0x3008, BrTaken=1, BrTarget=0x3103, Stall=0 -> same cycle NPC=0x3100, PCEn=1, FlushF=0. Next cycle with PC=0x3100: NPC=0x3104.
- Stall=1 for 3 cycles with a BrTaken pulse (target 0x3200) in the first cycle -> PCEn=0 for all 3 cycles, st=PEND. First Stall=0 cycle: NPC=0x3200, PCEn=1. Following cycle: NPC=PC+4.
- Stall=1, ExcReq=1, ExcPC=0x3010, InDelaySlot=1 -> same cycle NPC=0x4180, PCEn=1, FlushF=1. Next cycle EPC=0x300C. Repeat with InDelaySlot=0 and ExcPC=0x3020 -> EPC=0x3020.
- EPC=0x3020, Eret=1 and BrTaken=1 in the same cycle -> NPC=0x3020, PCEn=1, FlushF=1. EPC unchanged.
- In PEND (target 0x3300), Reset=1 for 1 cycle, then Stall=0 -> NPC=PC+4; the held target is never issued.
- PC=0xFFFF_FFFC, no event -> NPC=0x0000_0000.
